// File: rtl/sc_reggeneral_arbiter_pkg.sv
// Shared types and constants for the two-requester SC_RegGENERAL arbiter.
package sc_reggeneral_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAITREL = 2'd2,
        GAP     = 2'd3
    } state_e;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    localparam logic REQ0_IDX = 1'b0;
    localparam logic REQ1_IDX = 1'b1;

    localparam int unsigned NUM_REQ = 2;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return (idx == REQ1_IDX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sc_rr_arbiter2.sv
// Two-input round-robin pick with the last-served pointer; the pointer moves
// to the winner on every accepted grant.
module sc_rr_arbiter2
    import sc_reggeneral_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic               gnt_idx_c
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_idx_c = REQ0_IDX;
        if (req_i[0] && req_i[1]) begin
            gnt_idx_c = ~last_q;
        end else if (req_i[1]) begin
            gnt_idx_c = REQ1_IDX;
        end
        last_d = adv_i ? gnt_idx_c : last_q;
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ1_IDX;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sc_reggeneral_arbiter.sv
// Round-robin front end for SC_RegGENERAL: turns one granted request into a
// single-cycle active-low load/clear strobe, then waits for release and a guard gap.
module sc_reggeneral_arbiter
    import sc_reggeneral_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 SC_REGARBITER_CLOCK_50,
    input  logic                 SC_REGARBITER_RESET_InHigh,
    input  logic                 SC_REGARBITER_req0_InLow,
    input  logic                 SC_REGARBITER_op0_In,
    input  logic [DATAWIDTH-1:0] SC_REGARBITER_data0_InBUS,
    input  logic                 SC_REGARBITER_req1_InLow,
    input  logic                 SC_REGARBITER_op1_In,
    input  logic [DATAWIDTH-1:0] SC_REGARBITER_data1_InBUS,
    output logic                 SC_REGARBITER_load_OutLow,
    output logic                 SC_REGARBITER_clear_OutLow,
    output logic [DATAWIDTH-1:0] SC_REGARBITER_data_OutBUS,
    output logic [1:0]           SC_REGARBITER_ack_OutBUS,
    output logic                 SC_REGARBITER_busy_Out
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic clk;
    logic rst;
    assign clk = SC_REGARBITER_CLOCK_50;
    assign rst = SC_REGARBITER_RESET_InHigh;

    logic [NUM_REQ-1:0] req_c;
    logic               any_req_c;
    logic               adv_c;
    logic               gnt_idx_c;
    logic               gnt_op_c;
    logic [DATAWIDTH-1:0] gnt_data_c;

    state_e               state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 sel_q, sel_d;
    logic                 op_q, op_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic                 load_n_q, load_n_d;
    logic                 clear_n_q, clear_n_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [1:0]           ack_q, ack_d;
    logic                 busy_q, busy_d;

    assign req_c      = {~SC_REGARBITER_req1_InLow, ~SC_REGARBITER_req0_InLow};
    assign any_req_c  = |req_c;
    assign adv_c      = (state_q == IDLE) && any_req_c;
    assign gnt_op_c   = (gnt_idx_c == REQ1_IDX) ? SC_REGARBITER_op1_In : SC_REGARBITER_op0_In;
    assign gnt_data_c = (gnt_idx_c == REQ1_IDX) ? SC_REGARBITER_data1_InBUS
                                                : SC_REGARBITER_data0_InBUS;

    sc_rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_c),
        .adv_i     (adv_c),
        .gnt_idx_c (gnt_idx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next state and guard-gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAITREL;
            end
            WAITREL: begin
                if (!req_c[sel_q]) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant capture and strobe generation; strobes fire from the ISSUE state.
    always_comb begin
        sel_d     = sel_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        load_n_d  = 1'b1;
        clear_n_d = 1'b1;
        data_d    = data_q;
        ack_d     = 2'b00;
        busy_d    = (state_d != IDLE);
        if (adv_c) begin
            sel_d   = gnt_idx_c;
            op_d    = gnt_op_c;
            wdata_d = gnt_data_c;
        end
        if (state_q == ISSUE) begin
            ack_d = idx_to_onehot(sel_q);
            if (op_q == OP_LOAD) begin
                load_n_d = 1'b0;
                data_d   = wdata_q;
            end else begin
                clear_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= REQ0_IDX;
            op_q      <= OP_LOAD;
            wdata_q   <= '0;
            load_n_q  <= 1'b1;
            clear_n_q <= 1'b1;
            data_q    <= '0;
            ack_q     <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            load_n_q  <= load_n_d;
            clear_n_q <= clear_n_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign SC_REGARBITER_load_OutLow  = load_n_q;
    assign SC_REGARBITER_clear_OutLow = clear_n_q;
    assign SC_REGARBITER_data_OutBUS  = data_q;
    assign SC_REGARBITER_ack_OutBUS   = ack_q;
    assign SC_REGARBITER_busy_Out     = busy_q;

endmodule

// File: tb/tb_sc_reggeneral_arbiter.sv
// Directed bench for sc_reggeneral_arbiter; a second instance built with
// GAP_CYCLES=0 shares the stimulus to cover the no-gap release path.
module tb_sc_reggeneral_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_n, op0, req1_n, op1;
    logic [7:0] data0, data1;

    logic       load_n, clear_n, busy;
    logic [7:0] data_o;
    logic [1:0] ack;

    logic       load_n_g0, clear_n_g0, busy_g0;
    logic [7:0] data_o_g0;
    logic [1:0] ack_g0;

    int n_checks = 0;
    int n_pass   = 0;

    sc_reggeneral_arbiter #(.DATAWIDTH(8), .GAP_CYCLES(4)) u_dut (
        .SC_REGARBITER_CLOCK_50     (clk),
        .SC_REGARBITER_RESET_InHigh (rst),
        .SC_REGARBITER_req0_InLow   (req0_n),
        .SC_REGARBITER_op0_In       (op0),
        .SC_REGARBITER_data0_InBUS  (data0),
        .SC_REGARBITER_req1_InLow   (req1_n),
        .SC_REGARBITER_op1_In       (op1),
        .SC_REGARBITER_data1_InBUS  (data1),
        .SC_REGARBITER_load_OutLow  (load_n),
        .SC_REGARBITER_clear_OutLow (clear_n),
        .SC_REGARBITER_data_OutBUS  (data_o),
        .SC_REGARBITER_ack_OutBUS   (ack),
        .SC_REGARBITER_busy_Out     (busy)
    );

    sc_reggeneral_arbiter #(.DATAWIDTH(8), .GAP_CYCLES(0)) u_dut_g0 (
        .SC_REGARBITER_CLOCK_50     (clk),
        .SC_REGARBITER_RESET_InHigh (rst),
        .SC_REGARBITER_req0_InLow   (req0_n),
        .SC_REGARBITER_op0_In       (op0),
        .SC_REGARBITER_data0_InBUS  (data0),
        .SC_REGARBITER_req1_InLow   (req1_n),
        .SC_REGARBITER_op1_In       (op1),
        .SC_REGARBITER_data1_InBUS  (data1),
        .SC_REGARBITER_load_OutLow  (load_n_g0),
        .SC_REGARBITER_clear_OutLow (clear_n_g0),
        .SC_REGARBITER_data_OutBUS  (data_o_g0),
        .SC_REGARBITER_ack_OutBUS   (ack_g0),
        .SC_REGARBITER_busy_Out     (busy_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req0_n = 1'b1;
        req1_n = 1'b1;
        op0    = 1'b0;
        op1    = 1'b0;
        data0  = 8'h00;
        data1  = 8'h00;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        int cnt;
        int waited;
        logic [7:0] exp_data;

        // Reset values
        do_reset();
        check("rst_load", 32'(load_n), 32'd1);
        check("rst_clear", 32'(clear_n), 32'd1);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single load from requester 0, one cycle latency, one-cycle strobe
        req0_n = 1'b0; op0 = 1'b0; data0 = 8'hA5;
        step(1);
        check("a_busy_issue", 32'(busy), 32'd1);
        check("a_load_early", 32'(load_n), 32'd1);
        step(1);
        check("a_load", 32'(load_n), 32'd0);
        check("a_clear", 32'(clear_n), 32'd1);
        check("a_data", 32'(data_o), 32'hA5);
        check("a_ack", 32'(ack), 32'h1);
        step(1);
        check("a_load_end", 32'(load_n), 32'd1);
        check("a_ack_end", 32'(ack), 32'h0);
        req0_n = 1'b1;
        step(1);
        check("a_busy_gap", 32'(busy), 32'd1);
        check("a_g0_idle", 32'(busy_g0), 32'd0);
        step(3);
        check("a_busy_gap_end", 32'(busy), 32'd1);
        step(1);
        check("a_busy_idle", 32'(busy), 32'd0);

        // Clear from requester 1 keeps data
        req1_n = 1'b0; op1 = 1'b1; data1 = 8'hFF;
        step(2);
        check("d_clear", 32'(clear_n), 32'd0);
        check("d_load", 32'(load_n), 32'd1);
        check("d_data_hold", 32'(data_o), 32'hA5);
        check("d_ack", 32'(ack), 32'h2);
        step(1);
        check("d_clear_end", 32'(clear_n), 32'd1);
        req1_n = 1'b1;
        step(5);

        // Tie after reset: requester 0 first, requester 1 after release + gap
        do_reset();
        req0_n = 1'b0; op0 = 1'b0; data0 = 8'h11;
        req1_n = 1'b0; op1 = 1'b0; data1 = 8'h3C;
        step(2);
        check("b_ack0", 32'(ack), 32'h1);
        check("b_data0", 32'(data_o), 32'h11);
        step(1);
        req0_n = 1'b1;
        step(1);
        step(3);
        check("b_no_grant_gap", 32'(ack), 32'h0);
        step(1);
        check("b_busy_idle", 32'(busy), 32'd0);
        step(1);
        check("b_ack_early", 32'(ack), 32'h0);
        step(1);
        check("b_ack1", 32'(ack), 32'h2);
        check("b_load1", 32'(load_n), 32'd0);
        check("b_data1", 32'(data_o), 32'h3C);
        req1_n = 1'b1;
        step(6);

        // Both held, winner releases and re-asserts: grants alternate
        do_reset();
        req0_n = 1'b0; op0 = 1'b0; data0 = 8'h10;
        req1_n = 1'b0; op1 = 1'b0; data1 = 8'h21;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (ack == 2'b00 && waited < 20) begin
                step(1);
                waited++;
            end
            exp_data = (k % 2 == 0) ? 8'h10 : 8'h21;
            check($sformatf("c_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("c_data%0d", k), 32'(data_o), 32'(exp_data));
            if (k % 2 == 0) req0_n = 1'b1; else req1_n = 1'b1;
            step(1);
            if (k % 2 == 0) req0_n = 1'b0; else req1_n = 1'b0;
        end
        req0_n = 1'b1; req1_n = 1'b1;
        step(8);

        // Held button: one strobe only, block stays busy
        do_reset();
        req0_n = 1'b0; op0 = 1'b0; data0 = 8'h5A;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (load_n == 1'b0) cnt++;
        end
        check("e_one_strobe", 32'(cnt), 32'd1);
        check("e_busy_held", 32'(busy), 32'd1);
        req0_n = 1'b1;
        step(1);
        check("e_busy_gap", 32'(busy), 32'd1);
        check("e_g0_idle", 32'(busy_g0), 32'd0);
        step(4);
        check("e_busy_idle", 32'(busy), 32'd0);

        // Reset during ISSUE cuts off the strobe
        do_reset();
        req0_n = 1'b0; op0 = 1'b0; data0 = 8'h77;
        step(1);
        rst = 1'b1;
        step(1);
        check("f_load", 32'(load_n), 32'd1);
        check("f_ack", 32'(ack), 32'h0);
        check("f_data", 32'(data_o), 32'h0);
        check("f_busy", 32'(busy), 32'd0);
        check("f_g0_load", 32'(load_n_g0), 32'd1);
        rst = 1'b0; req0_n = 1'b1;
        step(1);
        check("f_load_after", 32'(load_n), 32'd1);
        check("f_busy_after", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
